// File: rtl/game_link_pkg.sv
// Shared ball-link definitions: state encoding, framing constants and the frame byte mux.
// Used by the TX scheduler now and by the RX decoder later.
package game_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    DONE
  } link_tx_state_e;

  localparam logic [7:0] LINK_SOF       = 8'hA5;
  localparam int         LINK_FRAME_LEN = 6;

  typedef logic [2:0] frame_idx_t;

  localparam frame_idx_t LINK_LAST_IDX = 3'(LINK_FRAME_LEN - 1);

  typedef struct packed {
    logic [7:0] vy;
    logic [7:0] speed0;
    logic [7:0] speed1;
    logic [3:0] speed2;
    logic [1:0] grav;
  } ball_snap_t;

  // B5 is the XOR of B1..B4 so the receiver can reject a corrupted frame.
  function automatic logic [7:0] frame_byte(input ball_snap_t s, input frame_idx_t idx);
    logic [7:0] b4;
    logic [7:0] res;
    b4 = {s.speed2, 2'b00, s.grav};
    case (idx)
      3'd0:    res = LINK_SOF;
      3'd1:    res = s.vy;
      3'd2:    res = s.speed0;
      3'd3:    res = s.speed1;
      3'd4:    res = b4;
      3'd5:    res = s.vy ^ s.speed0 ^ s.speed1 ^ b4;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/link_ack_timer.sv
// ACK wait timer: reloads while clear is high, counts down while enabled,
// and flags expire on the ACK_TIMEOUT-th enabled cycle.
module link_ack_timer #(
  parameter int ACK_TIMEOUT = 250_000
) (
  input  logic clk_25MHZ,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TIMER_W = $clog2(ACK_TIMEOUT);
  localparam logic [TIMER_W-1:0] LOAD = TIMER_W'(ACK_TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk_25MHZ or negedge reset) begin
    if (!reset) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/ball_link_tx_scheduler.sv
// Two-player ball hand-off: snapshots the ball on trigger, streams a 6-byte frame
// to the UART TX, waits for the peer ACK and retries on timeout.
//
//   state    | meaning
//   IDLE     | link quiet; waiting for a trigger or a pending frame
//   SEND     | presenting frame byte idx on the byte link
//   WAIT_ACK | whole frame sent; ACK timer running
//   DONE     | ACK seen; frame_sent pulses; pending frame launches from here
module ball_link_tx_scheduler
  import game_link_pkg::*;
#(
  parameter int ACK_TIMEOUT = 250_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       sw,
  input  logic       ball_send_trigger,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic [7:0] ball_speed_reg0,
  input  logic [7:0] ball_speed_reg1,
  input  logic [3:0] ball_speed_reg2,
  input  logic       ack_received,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_sent,
  output logic       link_error
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  link_tx_state_e     state;
  frame_idx_t         idx;
  ball_snap_t         snapshot;
  ball_snap_t         shadow;
  ball_snap_t         capture;
  logic               pending;
  logic [RETRY_W-1:0] retry_cnt;
  logic               ack_expire;
  logic               accepted;

  assign capture = '{vy: ball_vy, speed0: ball_speed_reg0, speed1: ball_speed_reg1,
                     speed2: ball_speed_reg2, grav: gravity_counter};
  assign accepted = tx_valid && tx_ready;

  link_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk_25MHZ(clk_25MHZ),
    .reset    (reset),
    .clear    (state != WAIT_ACK),
    .enable   (state == WAIT_ACK),
    .expire   (ack_expire)
  );

  always_ff @(posedge clk_25MHZ or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      snapshot   <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      retry_cnt  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_sent <= 1'b0;
      link_error <= 1'b0;
    end else begin
      frame_sent <= 1'b0;
      unique case (state)
        IDLE: begin
          // A fresh trigger supersedes a pending frame left over from retry exhaustion.
          if (sw && (ball_send_trigger || pending)) begin
            snapshot   <= ball_send_trigger ? capture : shadow;
            pending    <= 1'b0;
            retry_cnt  <= '0;
            link_error <= 1'b0;
            state      <= SEND;
            idx        <= '0;
            tx_valid   <= 1'b1;
            tx_data    <= LINK_SOF;
            busy       <= 1'b1;
          end
        end
        SEND: begin
          if (accepted) begin
            if (!sw || (idx == LINK_LAST_IDX)) begin
              state    <= sw ? WAIT_ACK : IDLE;
              busy     <= sw;
              tx_valid <= 1'b0;
              tx_data  <= '0;
            end else begin
              idx     <= idx + 1'b1;
              tx_data <= frame_byte(snapshot, idx + 1'b1);
            end
          end
        end
        WAIT_ACK: begin
          if (!sw) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (ack_received) begin
            state      <= DONE;
            frame_sent <= 1'b1;
          end else if (ack_expire) begin
            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= SEND;
              idx       <= '0;
              tx_valid  <= 1'b1;
              tx_data   <= LINK_SOF;
            end else begin
              link_error <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
        end
        DONE: begin
          if (sw && pending) begin
            snapshot   <= shadow;
            pending    <= 1'b0;
            retry_cnt  <= '0;
            link_error <= 1'b0;
            state      <= SEND;
            idx        <= '0;
            tx_valid   <= 1'b1;
            tx_data    <= LINK_SOF;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Placed after the case so a busy-time trigger overrides the pending clear in DONE.
      if (!sw) begin
        pending <= 1'b0;
      end else if (ball_send_trigger && (state != IDLE)) begin
        pending <= 1'b1;
        shadow  <= capture;
      end
    end
  end

endmodule

// File: tb/tb_ball_link_tx_scheduler.sv
// Directed/randomized bench for ball_link_tx_scheduler: a byte-stream model predicts every
// presented byte, and directed steps check timing, retries, pending frames, sw drop and reset.
module tb_ball_link_tx_scheduler;

  localparam int ACK_TIMEOUT = 20;
  localparam int MAX_RETRY   = 3;

  logic       clk_25MHZ = 1'b0;
  logic       reset = 1'b0;
  logic       sw = 1'b0;
  logic       ball_send_trigger = 1'b0;
  logic [7:0] ball_vy = '0;
  logic [1:0] gravity_counter = '0;
  logic [7:0] ball_speed_reg0 = '0;
  logic [7:0] ball_speed_reg1 = '0;
  logic [3:0] ball_speed_reg2 = '0;
  logic       ack_received = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       frame_sent;
  logic       link_error;

  always #5 clk_25MHZ = ~clk_25MHZ;

  ball_link_tx_scheduler #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk_25MHZ        (clk_25MHZ),
    .reset            (reset),
    .sw               (sw),
    .ball_send_trigger(ball_send_trigger),
    .ball_vy          (ball_vy),
    .gravity_counter  (gravity_counter),
    .ball_speed_reg0  (ball_speed_reg0),
    .ball_speed_reg1  (ball_speed_reg1),
    .ball_speed_reg2  (ball_speed_reg2),
    .ack_received     (ack_received),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .frame_sent       (frame_sent),
    .link_error       (link_error)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } acc_t;

  acc_t       acc[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         fs_cnt = 0;
  int         fs_cyc = -1;
  int         le_rise = -1;
  int         exp_fs = 0;
  int         last_t = 0;
  int         base = 0;
  int         ta = 0;
  int         n = 0;
  bit         rand_ready = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_le = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] v_vy, v_r0, v_r1;
  logic [3:0] v_r2;
  logic [1:0] v_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame from the ball fields, appended to the predicted byte stream.
  function automatic void push_frame(input int nbytes);
    logic [7:0] b[6];
    b[0] = 8'hA5;
    b[1] = v_vy;
    b[2] = v_r0;
    b[3] = v_r1;
    b[4] = 8'(v_r2 * 16 + v_g);
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
    for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
  endfunction

  // Monitor: one sample per cycle, mid-cycle, when DUT inputs and outputs are settled.
  always @(negedge clk_25MHZ) begin
    cyc++;
    if (reset && prev_rst && prev_stall) check("stall_valid_held", {31'b0, tx_valid}, 32'd1);
    if (reset && tx_valid) begin
      if (acc.size() < exp_q.size()) check("presented_byte", {24'b0, tx_data}, {24'b0, exp_q[acc.size()]});
      else check("unexpected_valid", {31'b0, tx_valid}, 32'd0);
      if (tx_ready) acc.push_back('{cyc: cyc, data: tx_data});
    end
    if (reset && frame_sent) begin
      fs_cnt++;
      fs_cyc = cyc;
    end
    if (reset && link_error && !prev_le) le_rise = cyc;
    prev_stall = reset && tx_valid && !tx_ready;
    prev_le    = link_error;
    prev_rst   = reset;
  end

  task automatic step();
    @(posedge clk_25MHZ);
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic new_ball();
    v_vy = 8'($urandom);
    v_r0 = 8'($urandom);
    v_r1 = 8'($urandom);
    v_r2 = 4'($urandom);
    v_g  = 2'($urandom);
  endtask

  // One-cycle trigger; inputs are scrambled afterwards so only the snapshot matters.
  task automatic fire();
    ball_vy           = v_vy;
    ball_speed_reg0   = v_r0;
    ball_speed_reg1   = v_r1;
    ball_speed_reg2   = v_r2;
    gravity_counter   = v_g;
    ball_send_trigger = 1'b1;
    last_t            = cyc + 1;
    step();
    ball_send_trigger = 1'b0;
    ball_vy           = 8'($urandom);
    ball_speed_reg0   = 8'($urandom);
    ball_speed_reg1   = 8'($urandom);
    ball_speed_reg2   = 4'($urandom);
    gravity_counter   = 2'($urandom);
  endtask

  task automatic ack_pulse();
    ack_received = 1'b1;
    step();
    ack_received = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int budget, input string tag);
    int k = 0;
    while (acc.size() < target && k < budget) begin
      step();
      k++;
    end
    check({tag, "_bytes_seen"}, acc.size(), target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd0);
    check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_frame_sent"}, {31'b0, frame_sent}, 32'd0);
    check({tag, "_link_error"}, {31'b0, link_error}, 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b1;
    step();
    step();
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Known frame, back-to-back bytes, single frame_sent pulse; stray ACK ignored.
    sw = 1'b1;
    tx_ready = 1'b1;
    v_vy = 8'h12; v_r0 = 8'h34; v_r1 = 8'h56; v_r2 = 4'h7; v_g = 2'b01;
    base = acc.size();
    push_frame(6);
    fire();
    wait_acc(base + 6, 20, "t1");
    for (int i = 0; i < 6; i++)
      if (acc.size() > base + i) check("t1_byte_cycle", acc[base+i].cyc, last_t + 1 + i);
    check("t1_wait_valid", {31'b0, tx_valid}, 32'd0);
    check("t1_wait_busy", {31'b0, busy}, 32'd1);
    step();
    ta = cyc + 1;
    ack_pulse();
    step();
    step();
    exp_fs++;
    check("t1_fs_cnt", fs_cnt, exp_fs);
    check("t1_fs_cycle", fs_cyc, ta + 1);
    check("t1_idle_busy", {31'b0, busy}, 32'd0);
    ack_pulse();
    repeat (3) step();
    check("stray_ack_fs", fs_cnt, exp_fs);

    // Random stalls on tx_ready.
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      new_ball();
      base = acc.size();
      push_frame(6);
      fire();
      wait_acc(base + 6, 300, "t2");
      ack_pulse();
      repeat (3) step();
      exp_fs++;
      check("t2_fs_cnt", fs_cnt, exp_fs);
    end
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    step();

    // No ACK: original plus MAX_RETRY resends, then link_error.
    new_ball();
    base = acc.size();
    for (int r = 0; r <= MAX_RETRY; r++) push_frame(6);
    le_rise = -1;
    fire();
    wait_acc(base + 24, 400, "t3");
    for (int f = 1; f < 4; f++)
      if (acc.size() >= base + 24)
        check("t3_retry_gap", acc[base+6*f].cyc - acc[base+6*f-1].cyc, ACK_TIMEOUT + 1);
    n = 0;
    while (le_rise < 0 && n < 60) begin
      step();
      n++;
    end
    if (acc.size() >= base + 24) check("t3_le_rise_cycle", le_rise, acc[base+23].cyc + ACK_TIMEOUT + 1);
    check("t3_link_error", {31'b0, link_error}, 32'd1);
    check("t3_busy", {31'b0, busy}, 32'd0);
    repeat (10) step();
    check("t3_le_sticky", {31'b0, link_error}, 32'd1);
    check("t3_no_extra_bytes", acc.size(), base + 24);
    check("t3_no_fs", fs_cnt, exp_fs);

    // Two triggers during WAIT_ACK: latest wins, exactly one extra frame.
    new_ball();
    base = acc.size();
    push_frame(6);
    fire();
    check("t4_le_cleared", {31'b0, link_error}, 32'd0);
    wait_acc(base + 6, 20, "t4_first");
    new_ball();
    v_vy = 8'h01;
    fire();
    new_ball();
    v_vy = 8'h02;
    push_frame(6);
    fire();
    ack_pulse();
    exp_fs++;
    wait_acc(base + 12, 40, "t4_second");
    if (acc.size() > base + 7) check("t4_latest_vy", {24'b0, acc[base+7].data}, 32'h02);
    ack_pulse();
    exp_fs++;
    repeat (30) step();
    check("t4_frame_count", acc.size(), base + 12);
    check("t4_fs_cnt", fs_cnt, exp_fs);
    check("t4_busy", {31'b0, busy}, 32'd0);

    // Trigger in the DONE cycle becomes a pending frame.
    new_ball();
    base = acc.size();
    push_frame(6);
    fire();
    wait_acc(base + 6, 20, "t4b_first");
    ta = cyc + 1;
    ack_pulse();
    new_ball();
    push_frame(6);
    fire();
    wait_acc(base + 12, 40, "t4b_pending");
    if (acc.size() > base + 6) check("t4b_start_cycle", acc[base+6].cyc, ta + 3);
    ack_pulse();
    repeat (3) step();
    exp_fs += 2;
    check("t4b_fs_cnt", fs_cnt, exp_fs);

    // sw drops while B2 is stalled: B2 completes, frame truncated, sw=0 trigger ignored.
    new_ball();
    base = acc.size();
    push_frame(3);
    fire();
    step();
    step();
    tx_ready = 1'b0;
    sw = 1'b0;
    repeat (4) step();
    check("t5_hold_valid", {31'b0, tx_valid}, 32'd1);
    check("t5_hold_data", {24'b0, tx_data}, {24'b0, exp_q[base+2]});
    check("t5_hold_busy", {31'b0, busy}, 32'd1);
    tx_ready = 1'b1;
    repeat (5) step();
    check("t5_truncated", acc.size(), base + 3);
    check("t5_valid_low", {31'b0, tx_valid}, 32'd0);
    check("t5_busy_low", {31'b0, busy}, 32'd0);
    new_ball();
    fire();
    repeat (10) step();
    check("t5_sw0_busy", {31'b0, busy}, 32'd0);
    check("t5_sw0_no_bytes", acc.size(), base + 3);

    // Asynchronous reset mid-SEND, then normal operation from IDLE.
    sw = 1'b1;
    tx_ready = 1'b0;
    new_ball();
    base = acc.size();
    push_frame(6);
    fire();
    step();
    check("t6_valid_held", {31'b0, tx_valid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("t6_async");
    while (exp_q.size() > acc.size()) void'(exp_q.pop_back());
    repeat (3) step();
    reset = 1'b1;
    tx_ready = 1'b1;
    repeat (10) step();
    check("t6_idle_busy", {31'b0, busy}, 32'd0);
    check("t6_idle_valid", {31'b0, tx_valid}, 32'd0);
    check("t6_no_bytes", acc.size(), base);
    new_ball();
    push_frame(6);
    fire();
    wait_acc(base + 6, 20, "t6_after");
    if (acc.size() > base) check("t6_b0_cycle", acc[base].cyc, last_t + 1);
    ack_pulse();
    repeat (3) step();
    exp_fs++;
    check("t6_fs_cnt", fs_cnt, exp_fs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
